// File: rtl/mc14500_core.sv
// mc14500_core: instruction-execution stage of an MC14500B-style 1-bit
// controller. Each accepted instruction runs IDLE -> ADDR -> EXEC, operating
// on the result register (RR) and the IEN/OEN enables. It drives a 1-bit data
// RAM and raises the FLAG0/FLAGF/JMP/RTN strobes.
module mc14500_core #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wdata,
  input  logic              ram_rdata,
  output logic              rr,
  output logic              flag0,
  output logic              flagf,
  output logic              jmp,
  output logic              rtn
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_EXEC} state_e;

  localparam logic [3:0] OP_NOPO = 4'h0, OP_LD   = 4'h1, OP_LDC  = 4'h2,
                         OP_AND  = 4'h3, OP_ANDC = 4'h4, OP_OR   = 4'h5,
                         OP_ORC  = 4'h6, OP_XNOR = 4'h7, OP_STO  = 4'h8,
                         OP_STOC = 4'h9, OP_IEN  = 4'hA, OP_OEN  = 4'hB,
                         OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ  = 4'hE,
                         OP_NOPF = 4'hF;

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rr_q, rr_d, ien_q, ien_d, oen_q, oen_d, skip_q, skip_d;
  logic                read_q, read_d, write_q, write_d, wdata_q, wdata_d;
  logic [3:0]          strb_q, strb_d;   // {flag0, flagf, jmp, rtn}
  logic [3:0]          op_nxt;
  logic                dat;

  // Opcodes that read their operand from RAM.
  function automatic logic is_data_op(input logic [3:0] op);
    return ((op >= OP_LD) && (op <= OP_XNOR)) || (op == OP_IEN) || (op == OP_OEN);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a fixed three-cycle walk once an instruction is taken.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_ADDR;
      S_ADDR:  state_d = S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered RAM controls and strobes,
  // decoded from the state being entered so the pins come straight off flops.
  always_comb begin
    read_d  = 1'b0;
    write_d = 1'b0;
    wdata_d = 1'b0;
    strb_d  = 4'b0000;
    op_nxt  = (state_q == S_IDLE) ? instr_op : op_q;
    if ((state_d != S_IDLE) && !skip_q) begin
      read_d = is_data_op(op_nxt);
      if (op_nxt == OP_STO)       wdata_d = rr_q;
      else if (op_nxt == OP_STOC) wdata_d = ~rr_q;
      if (state_d == S_EXEC) begin
        write_d = oen_q && ((op_nxt == OP_STO) || (op_nxt == OP_STOC));
        case (op_nxt)
          OP_NOPO: strb_d = 4'b1000;
          OP_NOPF: strb_d = 4'b0100;
          OP_JMP:  strb_d = 4'b0010;
          OP_RTN:  strb_d = 4'b0001;
          default: strb_d = 4'b0000;
        endcase
      end
    end
  end

  // Datapath: instruction latch on accept, RR/IEN/OEN/skip update at the end of EXEC.
  always_comb begin
    op_d   = op_q;
    addr_d = addr_q;
    rr_d   = rr_q;
    ien_d  = ien_q;
    oen_d  = oen_q;
    skip_d = skip_q;
    dat    = ram_rdata & ien_q;
    if ((state_q == S_IDLE) && instr_valid) begin
      op_d   = instr_op;
      addr_d = instr_addr;
    end
    if (state_q == S_EXEC) begin
      if (skip_q) begin
        skip_d = 1'b0;
      end else begin
        case (op_q)
          OP_LD:   rr_d = dat;
          OP_LDC:  rr_d = ~dat;
          OP_AND:  rr_d = rr_q & dat;
          OP_ANDC: rr_d = rr_q & ~dat;
          OP_OR:   rr_d = rr_q | dat;
          OP_ORC:  rr_d = rr_q | ~dat;
          OP_XNOR: rr_d = ~(rr_q ^ dat);
          OP_IEN:  ien_d = ram_rdata;
          OP_OEN:  oen_d = ram_rdata;
          OP_RTN:  skip_d = 1'b1;
          OP_SKZ:  skip_d = ~rr_q;
          default: ;
        endcase
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_NOPO;
      addr_q  <= '0;
      rr_q    <= 1'b0;
      ien_q   <= 1'b0;
      oen_q   <= 1'b0;
      skip_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= 1'b0;
      strb_q  <= 4'b0000;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      rr_q    <= rr_d;
      ien_q   <= ien_d;
      oen_q   <= oen_d;
      skip_q  <= skip_d;
      read_q  <= read_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign ram_read    = read_q;
  assign ram_write   = write_q;
  assign ram_wdata   = wdata_q;
  assign ram_address = addr_q;
  assign rr          = rr_q;
  assign flag0       = strb_q[3];
  assign flagf       = strb_q[2];
  assign jmp         = strb_q[1];
  assign rtn         = strb_q[0];

endmodule

// File: tb/tb_mc14500_core.sv
// Testbench for mc14500_core: directed table of instruction vectors, an
// asynchronous reset during a store, and random instructions checked against
// an instruction-level model of RR/IEN/OEN/skip.
module tb_mc14500_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready;
  logic [3:0] instr_op;
  logic [7:0] instr_addr;
  logic       ram_read, ram_write, ram_wdata, ram_rdata;
  logic [7:0] ram_address;
  logic       rr, flag0, flagf, jmp, rtn;
  logic [3:0] strb;

  int n_pass  = 0;
  int n_total = 0;

  // Instruction-level model state.
  bit m_rr, m_ien, m_oen, m_skip;

  typedef struct {
    logic [3:0] op;
    logic [7:0] addr;
    logic       rdata;
    logic       exp_rr;
    logic [3:0] exp_strb;
    logic       exp_wr;
  } vec_t;

  vec_t vecs[25];

  assign strb = {flag0, flagf, jmp, rtn};

  always #5 clk = ~clk;

  mc14500_core #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_addr  (instr_addr),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .rr          (rr),
    .flag0       (flag0),
    .flagf       (flagf),
    .jmp         (jmp),
    .rtn         (rtn)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] addr, input logic rdata,
                              input logic exp_rr, input logic [3:0] exp_strb, input logic exp_wr);
    vec_t v;
    v.op = op; v.addr = addr; v.rdata = rdata;
    v.exp_rr = exp_rr; v.exp_strb = exp_strb; v.exp_wr = exp_wr;
    return v;
  endfunction

  // Run one instruction starting at a falling edge in IDLE; returns at the
  // falling edge of the following IDLE cycle.
  task automatic issue(input logic [3:0] op, input logic [7:0] addr, input logic rdata,
                       output logic [3:0] seen_strb, output logic seen_wr);
    bit       exe, is_data, is_store, d;
    bit [3:0] e_strb;
    bit       e_wd;
    exe      = !m_skip;
    is_data  = (op >= 4'h1 && op <= 4'h7) || op == 4'hA || op == 4'hB;
    is_store = (op == 4'h8) || (op == 4'h9);
    e_strb   = 4'b0000;
    if (exe) begin
      if (op == 4'h0) e_strb = 4'b1000;
      if (op == 4'hF) e_strb = 4'b0100;
      if (op == 4'hC) e_strb = 4'b0010;
      if (op == 4'hD) e_strb = 4'b0001;
    end
    e_wd = (op == 4'h8) ? m_rr : !m_rr;

    check("ready_idle", instr_ready, 1);
    instr_valid = 1'b1; instr_op = op; instr_addr = addr; ram_rdata = rdata;
    @(negedge clk);  // ADDR
    check("ready_addr", instr_ready, 0);
    check("read_addr", ram_read, exe && is_data);
    check("write_addr", ram_write, 0);
    check("address_addr", ram_address, addr);
    if (exe && is_store) check("wdata_addr", ram_wdata, e_wd);
    // Valid stays high with other contents; the core must ignore it.
    instr_op = ~op; instr_addr = ~addr;
    @(negedge clk);  // EXEC
    check("ready_exec", instr_ready, 0);
    check("read_exec", ram_read, exe && is_data);
    check("write_exec", ram_write, exe && is_store && m_oen);
    check("address_exec", ram_address, addr);
    if (exe && is_store) check("wdata_exec", ram_wdata, e_wd);
    check("strobe_exec", strb, e_strb);
    seen_strb   = strb;
    seen_wr     = ram_write;
    instr_valid = 1'b0;

    // Model: effect of this instruction at the close of EXEC.
    if (!exe) begin
      m_skip = 1'b0;
    end else begin
      d = rdata & m_ien;
      case (op)
        4'h1: m_rr = d;
        4'h2: m_rr = !d;
        4'h3: m_rr = m_rr & d;
        4'h4: m_rr = m_rr & !d;
        4'h5: m_rr = m_rr | d;
        4'h6: m_rr = m_rr | !d;
        4'h7: m_rr = (m_rr == d);
        4'hA: m_ien = rdata;
        4'hB: m_oen = rdata;
        4'hD: m_skip = 1'b1;
        4'hE: m_skip = (m_rr == 1'b0);
        default: ;
      endcase
    end

    @(negedge clk);  // back in IDLE
    check("ready_after", instr_ready, 1);
    check("rr_after", rr, m_rr);
    check("read_after", ram_read, 0);
    check("write_after", ram_write, 0);
    check("strobe_after", strb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] s;
    logic       w;

    // op, addr, rdata, rr after, strobes {flag0,flagf,jmp,rtn}, write pulse
    vecs[0]  = mk(4'hB, 8'h00, 1, 0, 4'b0000, 0);  // OEN=1
    vecs[1]  = mk(4'h1, 8'h05, 1, 0, 4'b0000, 0);  // LD with IEN=0 -> 0
    vecs[2]  = mk(4'hA, 8'h01, 1, 0, 4'b0000, 0);  // IEN=1
    vecs[3]  = mk(4'hB, 8'h02, 1, 0, 4'b0000, 0);  // OEN=1
    vecs[4]  = mk(4'h1, 8'h03, 1, 1, 4'b0000, 0);  // LD -> 1
    vecs[5]  = mk(4'h9, 8'h09, 0, 1, 4'b0000, 1);  // STOC writes 0
    vecs[6]  = mk(4'hB, 8'h02, 0, 1, 4'b0000, 0);  // OEN=0
    vecs[7]  = mk(4'h8, 8'h04, 0, 1, 4'b0000, 0);  // STO, no write
    vecs[8]  = mk(4'h1, 8'h00, 0, 0, 4'b0000, 0);  // LD -> 0
    vecs[9]  = mk(4'hE, 8'h00, 0, 0, 4'b0000, 0);  // SKZ arms skip
    vecs[10] = mk(4'hF, 8'h00, 0, 0, 4'b0000, 0);  // skipped NOPF
    vecs[11] = mk(4'hF, 8'h00, 0, 0, 4'b0100, 0);  // NOPF
    vecs[12] = mk(4'hD, 8'h00, 0, 0, 4'b0001, 0);  // RTN arms skip
    vecs[13] = mk(4'hC, 8'h00, 0, 0, 4'b0000, 0);  // skipped JMP
    vecs[14] = mk(4'hC, 8'h00, 0, 0, 4'b0010, 0);  // JMP
    vecs[15] = mk(4'h0, 8'h00, 0, 0, 4'b1000, 0);  // NOPO
    vecs[16] = mk(4'h7, 8'h01, 1, 0, 4'b0000, 0);  // XNOR(0,1)=0
    vecs[17] = mk(4'h2, 8'hFF, 0, 1, 4'b0000, 0);  // LDC top address
    vecs[18] = mk(4'h6, 8'h01, 1, 1, 4'b0000, 0);  // ORC: 1|0
    vecs[19] = mk(4'h4, 8'h01, 1, 0, 4'b0000, 0);  // ANDC: 1&0
    vecs[20] = mk(4'h5, 8'h01, 1, 1, 4'b0000, 0);  // OR: 0|1
    vecs[21] = mk(4'h3, 8'h01, 0, 0, 4'b0000, 0);  // AND: 1&0
    vecs[22] = mk(4'hE, 8'h00, 0, 0, 4'b0000, 0);  // SKZ arms skip
    vecs[23] = mk(4'hD, 8'h00, 0, 0, 4'b0000, 0);  // skipped RTN, no re-arm
    vecs[24] = mk(4'hC, 8'h00, 0, 0, 4'b0010, 0);  // JMP runs

    rst_n = 1'b0; instr_valid = 1'b0; instr_op = 4'h0; instr_addr = 8'h00; ram_rdata = 1'b0;
    m_rr = 0; m_ien = 0; m_oen = 0; m_skip = 0;
    #12;
    check("rst_ready", instr_ready, 1);
    check("rst_rr", rr, 0);
    check("rst_read", ram_read, 0);
    check("rst_write", ram_write, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_address", ram_address, 0);
    check("rst_strobes", strb, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      issue(vecs[i].op, vecs[i].addr, vecs[i].rdata, s, w);
      check($sformatf("tbl%0d_rr", i), rr, vecs[i].exp_rr);
      check($sformatf("tbl%0d_strb", i), s, vecs[i].exp_strb);
      check($sformatf("tbl%0d_wr", i), w, vecs[i].exp_wr);
    end

    // Reset asserted during the EXEC cycle of a store with OEN=1.
    issue(4'hB, 8'h10, 1, s, w);
    issue(4'h1, 8'h11, 1, s, w);
    check("pre_rst_rr", rr, 1);
    instr_valid = 1'b1; instr_op = 4'h8; instr_addr = 8'h80;
    @(negedge clk);
    instr_valid = 1'b0;
    check("rst_seq_addr", ram_address, 8'h80);
    check("rst_seq_wdata", ram_wdata, 1);
    @(negedge clk);
    check("rst_seq_write_hi", ram_write, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_seq_write_lo", ram_write, 0);
    check("rst_seq_rr", rr, 0);
    check("rst_seq_ready", instr_ready, 1);
    check("rst_seq_address", ram_address, 0);
    #1 rst_n = 1'b1;
    m_rr = 0; m_ien = 0; m_oen = 0; m_skip = 0;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1);
    check("post_rst_rr", rr, 0);
    issue(4'h1, 8'h22, 1, s, w);  // IEN cleared by reset -> rr stays 0
    check("post_rst_ld", rr, 0);

    // Random instruction stream against the model.
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), s, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
